// File: rtl/uart_pkg.sv
// uart_pkg: Uart register map, status/control encodings and drain FSM states.
package uart_pkg;
  localparam logic [1:0] REG_TXDATA = 2'b00;
  localparam logic [1:0] REG_RXDATA = 2'b01;
  localparam logic [1:0] REG_CTRL = 2'b10;
  localparam logic [1:0] REG_STATUS = 2'b11;
  localparam int STAT_TX_BUSY = 0;
  localparam int STAT_RX_VALID = 1;
  localparam logic [7:0] CTRL_START = 8'h01;
  typedef enum logic [2:0] {S_IDLE, S_POLL, S_LOAD, S_START, S_GUARD} drain_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular DEPTH x 8 byte store with push/pop, occupancy count and drop flag.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_drop
);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = r_mem[r_rp];
  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_drop = i_push && o_full;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_wp <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: CPU byte queue drained into the Uart via poll-status / write-data / start.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push_valid,
  input  logic [7:0]    i_push_data,
  input  logic          i_clear_overflow,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_uart_write_enable,
  output logic          o_uart_read_enable,
  output logic [1:0]    o_uart_reg_select,
  output logic [7:0]    o_uart_write_data,
  input  logic [7:0]    i_uart_data
);
  drain_state_t r_state;
  logic r_overflow;
  logic [7:0] w_head;
  logic w_drop, w_busy, w_unused;
  assign w_busy = i_uart_data[STAT_TX_BUSY];
  assign w_unused = ^{i_uart_data[7:2], i_uart_data[STAT_RX_VALID]};
  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(i_push_valid),
    .i_data(i_push_data),
    .i_pop(r_state == S_LOAD),
    .o_data(w_head),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_count(o_count),
    .o_drop(w_drop)
  );
  assign o_overflow = r_overflow;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop ? 1'b1 : i_clear_overflow ? 1'b0 : r_overflow;
      case (r_state)
        S_IDLE:  r_state <= o_empty ? S_IDLE : S_POLL;
        S_POLL:  r_state <= w_busy ? S_POLL : S_LOAD;
        S_LOAD:  r_state <= S_START;
        S_START: r_state <= S_GUARD;
        S_GUARD: r_state <= o_empty ? S_IDLE : S_POLL;
        default: r_state <= S_IDLE;
      endcase
    end
  always_comb begin
    o_uart_read_enable = r_state == S_POLL;
    o_uart_write_enable = r_state == S_LOAD || r_state == S_START;
    o_uart_reg_select = r_state == S_POLL ? REG_STATUS : r_state == S_START ? REG_CTRL : REG_TXDATA;
    o_uart_write_data = r_state == S_LOAD ? w_head : r_state == S_START ? CTRL_START : 8'h00;
  end
endmodule
